// File: rtl/date_pkg.sv
// Shared calendar helpers for the date counter: field-select encodings,
// weekday constants and leap/month-length/weekday-step functions.
package date_pkg;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_DAY  = 2'b01;
  localparam logic [1:0] SEL_MON  = 2'b10;
  localparam logic [1:0] SEL_YEAR = 2'b11;

  localparam logic [2:0] DOW_SUN = 3'd0;
  localparam logic [2:0] DOW_MON = 3'd1;
  localparam logic [2:0] DOW_TUE = 3'd2;
  localparam logic [2:0] DOW_WED = 3'd3;
  localparam logic [2:0] DOW_THU = 3'd4;
  localparam logic [2:0] DOW_FRI = 3'd5;
  localparam logic [2:0] DOW_SAT = 3'd6;

  function automatic logic is_leap(input logic [31:0] year);
    return ((year % 32'd4 == 32'd0) && (year % 32'd100 != 32'd0)) ||
           (year % 32'd400 == 32'd0);
  endfunction

  function automatic logic [4:0] month_len(input logic [3:0] mm, input logic leap);
    case (mm)
      4'd2:                       month_len = leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:    month_len = 5'd30;
      default:                    month_len = 5'd31;
    endcase
  endfunction

  // Weekday successor, Saturday wraps to Sunday.
  function automatic logic [2:0] dow_next(input logic [2:0] d);
    return (d == DOW_SAT) ? DOW_SUN : d + 3'd1;
  endfunction

endpackage

// File: rtl/dow_calc.sv
// Combinational Sakamoto day-of-week (0=Sun..6=Sat) for a Gregorian date.
module dow_calc
  import date_pkg::*;
#(
  parameter int unsigned YEAR_W = 14
) (
  input  logic [4:0]        dd,
  input  logic [3:0]        mm,
  input  logic [YEAR_W-1:0] yyyy,
  output logic [2:0]        dow_c
);

  logic [3:0]  t;
  logic [31:0] y;
  logic [31:0] sum;

  // Year offset by 400 (a whole number of weeks) so Jan/Feb of year 0 stays non-negative.
  always_comb begin
    case (mm)
      4'd2:    t = 4'd3;
      4'd3:    t = 4'd2;
      4'd4:    t = 4'd5;
      4'd5:    t = 4'd0;
      4'd6:    t = 4'd3;
      4'd7:    t = 4'd5;
      4'd8:    t = 4'd1;
      4'd9:    t = 4'd4;
      4'd10:   t = 4'd6;
      4'd11:   t = 4'd2;
      4'd12:   t = 4'd4;
      default: t = 4'd0;
    endcase
    y     = 32'(yyyy) + 32'd400 - ((mm < 4'd3) ? 32'd1 : 32'd0);
    sum   = y + y / 32'd4 - y / 32'd100 + y / 32'd400 + 32'(t) + 32'(dd);
    dow_c = 3'(sum % 32'd7);
  end

endmodule

// File: rtl/datecounter_param.sv
// Calendar date counter with parametrised year range, wrap/saturate limits,
// freeze-mode editing and optional day-of-week tracking (DATECOUNTER_DOW_EN).
module datecounter_param
  import date_pkg::*;
#(
  parameter int unsigned YEAR_W    = 14,
  parameter int unsigned YEAR_MIN  = 0,
  parameter int unsigned YEAR_MAX  = 9999,
  parameter int unsigned YEAR_INIT = 2000,
  parameter int unsigned YEAR_WRAP = 1,
  parameter int unsigned DOW_INIT  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dayroll,
  input  logic              freeze,
  input  logic              inc,
  input  logic              dec,
  input  logic [1:0]        sel,
  output logic [4:0]        dd,
  output logic [3:0]        mm,
  output logic [YEAR_W-1:0] yyyy,
  output logic              leap,
  output logic              yearroll
`ifdef DATECOUNTER_DOW_EN
  ,
  output logic [2:0]        dow,
  output logic              dow_valid
`endif
);

  localparam logic [YEAR_W-1:0] YMIN  = YEAR_W'(YEAR_MIN);
  localparam logic [YEAR_W-1:0] YMAX  = YEAR_W'(YEAR_MAX);
  localparam logic [YEAR_W-1:0] YINIT = YEAR_W'(YEAR_INIT);
  localparam logic              WRAP  = (YEAR_WRAP != 0);

  logic [4:0]        dd_n;
  logic [3:0]        mm_n;
  logic [YEAR_W-1:0] yyyy_n;
  logic              yearroll_n;
  logic [4:0]        len;
  logic [4:0]        clamp_len;
  logic [YEAR_W-1:0] yr_up;
  logic [YEAR_W-1:0] yr_dn;

  assign leap = is_leap(32'(yyyy));

  // Next date: dayroll counting when running, single-field steps when frozen.
  always_comb begin
    dd_n       = dd;
    mm_n       = mm;
    yyyy_n     = yyyy;
    yearroll_n = 1'b0;
    len        = month_len(mm, leap);
    yr_up      = (yyyy == YMAX) ? (WRAP ? YMIN : YMAX) : yyyy + YEAR_W'(1);
    yr_dn      = (yyyy == YMIN) ? (WRAP ? YMAX : YMIN) : yyyy - YEAR_W'(1);
    if (!freeze) begin
      if (dayroll) begin
        if (dd < len) begin
          dd_n = dd + 5'd1;
        end else if (mm != 4'd12) begin
          dd_n = 5'd1;
          mm_n = mm + 4'd1;
        end else if (yyyy != YMAX || WRAP) begin
          dd_n       = 5'd1;
          mm_n       = 4'd1;
          yyyy_n     = yr_up;
          yearroll_n = 1'b1;
        end
      end
    end else if (inc ^ dec) begin
      case (sel)
        SEL_DAY: begin
          if (inc) dd_n = (dd >= len)  ? 5'd1 : dd + 5'd1;
          else     dd_n = (dd <= 5'd1) ? len  : dd - 5'd1;
        end
        SEL_MON: begin
          if (inc) mm_n = (mm >= 4'd12) ? 4'd1  : mm + 4'd1;
          else     mm_n = (mm <= 4'd1)  ? 4'd12 : mm - 4'd1;
        end
        SEL_YEAR: yyyy_n = inc ? yr_up : yr_dn;
        default: ;
      endcase
    end
    // Month/year edits may shorten the month; pull the day back inside it.
    clamp_len = month_len(mm_n, is_leap(32'(yyyy_n)));
    if (dd_n > clamp_len) dd_n = clamp_len;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dd       <= 5'd1;
      mm       <= 4'd1;
      yyyy     <= YINIT;
      yearroll <= 1'b0;
    end else begin
      dd       <= dd_n;
      mm       <= mm_n;
      yyyy     <= yyyy_n;
      yearroll <= yearroll_n;
    end
  end

`ifdef DATECOUNTER_DOW_EN
  logic [2:0] dow_cur_c;
  logic [2:0] dow_n;
  logic       dow_valid_n;

  dow_calc #(.YEAR_W(YEAR_W)) u_dow_calc (
    .dd    (dd),
    .mm    (mm),
    .yyyy  (yyyy),
    .dow_c (dow_cur_c)
  );

  // Freeze invalidates the tracker; the first running cycle reloads it from the date.
  always_comb begin
    dow_n       = dow;
    dow_valid_n = dow_valid;
    if (freeze) begin
      dow_valid_n = 1'b0;
    end else if (!dow_valid) begin
      dow_n       = dayroll ? dow_next(dow_cur_c) : dow_cur_c;
      dow_valid_n = 1'b1;
    end else if (dayroll) begin
      dow_n = dow_next(dow);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dow       <= 3'(DOW_INIT);
      dow_valid <= 1'b1;
    end else begin
      dow       <= dow_n;
      dow_valid <= dow_valid_n;
    end
  end
`else
  // DOW_INIT only matters when the weekday tracker is built.
  if (DOW_INIT > 6) begin : g_dow_init_unused
  end
`endif

endmodule

// File: tb/tb_datecounter_param.sv
// Directed self-checking bench: a wrapping (default) and a saturating instance
// driven by the same stimulus, compared against hand-computed dates.
module tb_datecounter_param;
  import date_pkg::*;

  logic        clk = 1'b0;
  logic        rst, dayroll, freeze, inc, dec;
  logic [1:0]  sel;
  logic [4:0]  a_dd, b_dd;
  logic [3:0]  a_mm, b_mm;
  logic [13:0] a_yyyy, b_yyyy;
  logic        a_leap, b_leap, a_yearroll, b_yearroll;
`ifdef DATECOUNTER_DOW_EN
  logic [2:0]  a_dow, b_dow;
  logic        a_dow_valid, b_dow_valid;
`endif

  int errors = 0;
  int checks = 0;
  int cur_d, cur_m, cur_y;

  always #5 clk = ~clk;

  datecounter_param #(.YEAR_WRAP(1)) u_wrap (
    .clk(clk), .rst(rst), .dayroll(dayroll), .freeze(freeze), .inc(inc), .dec(dec),
    .sel(sel), .dd(a_dd), .mm(a_mm), .yyyy(a_yyyy), .leap(a_leap), .yearroll(a_yearroll)
`ifdef DATECOUNTER_DOW_EN
    , .dow(a_dow), .dow_valid(a_dow_valid)
`endif
  );

  datecounter_param #(.YEAR_WRAP(0)) u_sat (
    .clk(clk), .rst(rst), .dayroll(dayroll), .freeze(freeze), .inc(inc), .dec(dec),
    .sel(sel), .dd(b_dd), .mm(b_mm), .yyyy(b_yyyy), .leap(b_leap), .yearroll(b_yearroll)
`ifdef DATECOUNTER_DOW_EN
    , .dow(b_dow), .dow_valid(b_dow_valid)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input int d, input int m, input int y, input int yr);
    check({tag, " wrap.dd"}, 32'(a_dd), d);
    check({tag, " wrap.mm"}, 32'(a_mm), m);
    check({tag, " wrap.yyyy"}, 32'(a_yyyy), y);
    check({tag, " wrap.yearroll"}, 32'(a_yearroll), yr);
  endtask

  task automatic check_b(input string tag, input int d, input int m, input int y, input int yr);
    check({tag, " sat.dd"}, 32'(b_dd), d);
    check({tag, " sat.mm"}, 32'(b_mm), m);
    check({tag, " sat.yyyy"}, 32'(b_yyyy), y);
    check({tag, " sat.yearroll"}, 32'(b_yearroll), yr);
  endtask

  task automatic expect_both(input string tag, input int d, input int m, input int y, input int yr);
    check_a(tag, d, m, y, yr);
    check_b(tag, d, m, y, yr);
    cur_d = d; cur_m = m; cur_y = y;
  endtask

  task automatic edit(input logic [1:0] s, input logic up, input int n);
    freeze = 1'b1;
    sel    = s;
    inc    = up;
    dec    = !up;
    repeat (n) tick();
    inc = 1'b0;
    dec = 1'b0;
    sel = SEL_NONE;
  endtask

  // Navigate by edits from the tracked date; day goes to 1 first so no clamping occurs.
  task automatic goto(input int d, input int m, input int y);
    edit(SEL_DAY, 1'b0, cur_d - 1);
    edit(SEL_YEAR, y > cur_y, (y > cur_y) ? y - cur_y : cur_y - y);
    edit(SEL_MON, m > cur_m, (m > cur_m) ? m - cur_m : cur_m - m);
    edit(SEL_DAY, 1'b1, d - 1);
    expect_both($sformatf("goto %0d/%0d/%0d", d, m, y), d, m, y, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cur_d = 1; cur_m = 1; cur_y = 2000;
  endtask

  task automatic roll_once();
    freeze  = 1'b0;
    dayroll = 1'b1;
    tick();
    dayroll = 1'b0;
  endtask

  initial begin
    rst = 1'b0; dayroll = 1'b0; freeze = 1'b0; inc = 1'b0; dec = 1'b0; sel = SEL_NONE;
    tick();
    do_reset();
    expect_both("reset", 1, 1, 2000, 0);
    check("reset leap", 32'(a_leap), 1);
`ifdef DATECOUNTER_DOW_EN
    check("reset dow", 32'(a_dow), 6);
    check("reset dow_valid", 32'(a_dow_valid), 1);
`endif

    // Leap rollovers
    goto(28, 2, 2024);
    roll_once();
    expect_both("leap2024 a", 29, 2, 2024, 0);
    roll_once();
    expect_both("leap2024 b", 1, 3, 2024, 0);
    goto(28, 2, 1900);
    check("leap 1900", 32'(a_leap), 0);
    roll_once();
    expect_both("century 1900", 1, 3, 1900, 0);
    goto(28, 2, 2000);
    check("leap 2000", 32'(a_leap), 1);
    roll_once();
    expect_both("quad century 2000", 29, 2, 2000, 0);

    // Clamping and day wrap in edit mode
    goto(31, 3, 2024);
    edit(SEL_MON, 1'b0, 1);
    expect_both("clamp mon dec", 29, 2, 2024, 0);
    edit(SEL_YEAR, 1'b1, 1);
    expect_both("clamp year inc", 28, 2, 2025, 0);
    edit(SEL_DAY, 1'b1, 1);
    expect_both("day inc wrap feb", 1, 2, 2025, 0);
    goto(1, 2, 2023);
    edit(SEL_DAY, 1'b0, 1);
    expect_both("day dec wrap feb", 28, 2, 2023, 0);
    goto(31, 1, 2023);
    edit(SEL_DAY, 1'b1, 1);
    expect_both("day inc wrap jan", 1, 1, 2023, 0);
    goto(1, 12, 2023);
    edit(SEL_MON, 1'b1, 1);
    expect_both("month inc no carry", 1, 1, 2023, 0);

    // Year boundary with dayroll held high
    goto(30, 12, 2024);
    freeze  = 1'b0;
    dayroll = 1'b1;
    tick();
    expect_both("yb 31/12", 31, 12, 2024, 0);
    tick();
    expect_both("yb 1/1", 1, 1, 2025, 1);
    tick();
    expect_both("yb 2/1", 2, 1, 2025, 0);
    dayroll = 1'b0;

    // Conflicts
    goto(15, 6, 2024);
    freeze = 1'b1; sel = SEL_DAY; inc = 1'b1; dec = 1'b1;
    tick(); tick();
    expect_both("inc and dec", 15, 6, 2024, 0);
    sel = SEL_NONE; dec = 1'b0;
    tick();
    expect_both("sel none", 15, 6, 2024, 0);
    inc = 1'b0; dayroll = 1'b1;
    tick();
    expect_both("dayroll in freeze", 15, 6, 2024, 0);
    dayroll = 1'b0; freeze = 1'b0; sel = SEL_DAY; inc = 1'b1;
    tick();
    expect_both("inc while running", 15, 6, 2024, 0);
    freeze = 1'b1; sel = SEL_YEAR; rst = 1'b1;
    tick();
    rst = 1'b0; inc = 1'b0; sel = SEL_NONE;
    cur_d = 1; cur_m = 1; cur_y = 2000;
    expect_both("reset mid edit", 1, 1, 2000, 0);

    // Upper year limit: wrap vs saturate
    goto(31, 12, 9999);
    roll_once();
    check_a("max roll", 1, 1, 0, 1);
    check_b("max roll", 31, 12, 9999, 0);
    tick();
    check_a("max roll after", 1, 1, 0, 0);
    check_b("max roll after", 31, 12, 9999, 0);
    do_reset();

    // Lower year limit via year edit
    goto(1, 1, 0);
    edit(SEL_YEAR, 1'b0, 1);
    check_a("min year dec", 1, 1, 9999, 0);
    check_b("min year dec", 1, 1, 0, 0);
    freeze = 1'b0;
    do_reset();

`ifdef DATECOUNTER_DOW_EN
    goto(1, 1, 2024);
    check("dow invalid in freeze", 32'(a_dow_valid), 0);
    freeze = 1'b0;
    tick();
    check("dow reload", 32'(a_dow), 1);
    check("dow valid reload", 32'(a_dow_valid), 1);
    freeze = 1'b1;
    tick();
    check("dow invalid again", 32'(a_dow_valid), 0);
    freeze  = 1'b0;
    dayroll = 1'b1;
    tick();
    check("dow reload with roll", 32'(a_dow), 2);
    check("dow reload date", 32'(a_dd), 2);
    tick();
    check("dow advance", 32'(a_dow), 3);
    dayroll = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
